// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths, register constants and the writeback request type.
package wb_arbiter_pkg;
  localparam int XLEN = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-write busy bits; with WB_BYPASS_EN a write clears its bit at the accepting edge.
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  acc_en,
  input  logic [REG_ADDR_W-1:0] acc_rd,
  output logic [NUM_REGS-1:0]   busy
);
  logic [NUM_REGS-1:0] set_mask, clr_mask;
  assign set_mask = (set_en && set_rd != REG_ZERO) ? NUM_REGS'(1) << set_rd : '0;
`ifdef WB_BYPASS_EN
  assign clr_mask = acc_en ? NUM_REGS'(1) << acc_rd : '0;
`else
  // Mirrors {wb_en, wb_addr}, so busy falls only once the register file holds the value.
  logic                  pend_en;
  logic [REG_ADDR_W-1:0] pend_rd;
  assign clr_mask = pend_en ? NUM_REGS'(1) << pend_rd : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pend_en <= 1'b0;
      pend_rd <= REG_ZERO;
    end else begin
      pend_en <= acc_en;
      pend_rd <= acc_rd;
    end
`endif
  // Set wins over clear: a newer producer for the same register is in flight.
  always_ff @(posedge clk or negedge reset)
    if (!reset) busy <= '0;
    else busy <= ((busy & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: MEM-priority writeback arbiter with ALU starvation guard and busy scoreboard.
// Optional WB_BYPASS_EN adds two bypass read ports and same-edge busy clear.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
`ifdef WB_BYPASS_EN
  input  logic [REG_ADDR_W-1:0] byp_addr1,
  input  logic [REG_ADDR_W-1:0] byp_addr2,
  output logic                  byp_hit1,
  output logic                  byp_hit2,
  output logic [XLEN-1:0]       byp_data1,
  output logic [XLEN-1:0]       byp_data2,
`endif
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [XLEN-1:0]       wb_data,
  output logic [NUM_REGS-1:0]   busy
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;
  logic          starve_hit, xfer, acc_en;
  wb_req_t       alu_req, mem_req, win;
  assign alu_req = '{rd: alu_rd, data: alu_data};
  assign mem_req = '{rd: mem_rd, data: mem_data};
  always_comb begin
    starve_hit = starve_cnt == SW'(STARVE_LIMIT);
    alu_ready  = reset && alu_valid && (!mem_valid || starve_hit);
    mem_ready  = reset && mem_valid && !(alu_valid && starve_hit);
    xfer       = alu_ready || mem_ready;
    win        = alu_ready ? alu_req : mem_req;
    acc_en     = xfer && win.rd != REG_ZERO;
  end
  // The counter only advances while the ALU is losing, so it can never pass the limit.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wb_en      <= 1'b0;
      wb_addr    <= REG_ZERO;
      wb_data    <= '0;
      starve_cnt <= '0;
    end else begin
      wb_en      <= acc_en;
      wb_addr    <= xfer ? win.rd : wb_addr;
      wb_data    <= xfer ? win.data : wb_data;
      starve_cnt <= (alu_ready || !alu_valid) ? '0 : starve_cnt + SW'(1);
    end
`ifdef WB_BYPASS_EN
  assign byp_hit1  = wb_en && wb_addr == byp_addr1 && byp_addr1 != REG_ZERO;
  assign byp_hit2  = wb_en && wb_addr == byp_addr2 && byp_addr2 != REG_ZERO;
  assign byp_data1 = wb_data;
  assign byp_data2 = wb_data;
`endif
  wb_scoreboard u_sb (
    .clk    (clk),
    .reset  (reset),
    .set_en (issue_en),
    .set_rd (issue_rd),
    .acc_en (acc_en),
    .acc_rd (win.rd),
    .busy   (busy)
  );
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file; sole driver of its wb_en/wb_addr/wb_data port.
- Arbitrates completed results from the ALU path and the memory (load) path onto the single write port, one per cycle.
- Keeps a per-register pending-write scoreboard (busy bits) that decode uses for RAW hazard stalls.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles the ALU may lose to MEM before the ALU is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- issue_en  in  1  instruction with a destination register issued this cycle.
- issue_rd  in  5  destination of issued instruction.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  5  ALU destination.
- alu_data  in  64  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  load result accepted this cycle.
- mem_rd  in  5  load destination.
- mem_data  in  64  load result.
- wb_en  out  1  register-file write enable.
- wb_addr  out  5  register-file write address.
- wb_data  out  64  register-file write data.
- busy  out  32  bit i = write to xi pending; bit 0 is always 0.

Behaviour:
- Reset (reset low, asynchronous): wb_en=0, wb_addr=0, wb_data=0, busy=0, starve counter=0, pending-clear register=0. alu_ready/mem_ready are 0 while reset is low.
- Handshake: valid/ready; a transfer occurs when valid&&ready at a posedge. A producer holds valid, rd and data stable until accepted. Ready is a combinational grant, never asserted without valid. At most one grant per cycle.
- Arbitration: MEM has priority. ALU wins if mem_valid=0, or if starve_cnt==STARVE_LIMIT.
- Starve counter (width $clog2(STARVE_LIMIT+1)):
  - +1 on each cycle where both are valid and MEM wins.
  - Cleared when the ALU is granted or alu_valid=0.
  - Never exceeds STARVE_LIMIT.
- Output stage: registered, 1-cycle latency. At the accepting edge, wb_addr/wb_data load the winner's rd/data and wb_en=1. If no transfer occurs, wb_en=0 and wb_addr/wb_data hold their values.
- rd==0: the transfer is accepted (ready asserted normally), but wb_en stays 0 and the scoreboard is unaffected.
- Scoreboard set: busy[issue_rd] is set at the edge where issue_en=1 and issue_rd!=0.
- Scoreboard clear, base build: the register is cleared one edge after wb_en is high. A pending-clear register captures {wb_en, wb_addr}. This guarantees a decode reading the register file combinationally sees the written value once busy falls.
- Set/clear same register at the same edge: set wins, because a newer producer exists.
- Simultaneous valid with identical rd on both ports: MEM goes first, ALU next free cycle. Program order is the issuer's responsibility.
- Reset mid-transfer: the in-flight output is discarded and busy is cleared. Producers re-present after reset; issue logic must flush.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined, adds these ports:
  - byp_addr1 in 5, byp_addr2 in 5.
  - byp_hit1 out 1, byp_hit2 out 1.
  - byp_data1 out 64, byp_data2 out 64.
- Hit/data: byp_hitN = wb_en && wb_addr==byp_addrN && byp_addrN!=0; byp_dataN = wb_data. Combinational from the registered outputs.
- Busy clears at the accepting edge itself, the same edge wb_en rises, saving one stall cycle. Set-wins rule is unchanged.
- Undefined: no bypass ports; one-edge-delayed clear as above.

Decomposition:
- Shared package: REG_ZERO=5'd0, XLEN=64, REG_ADDR_W=5, NUM_REGS=32, and a wb_req_t struct {rd, data}.
- One natural sub-module, wb_scoreboard: busy vector, set/clear/priority logic and the pending-clear register. The arbiter top holds the grant logic, starve counter and output flops.

Test Plan:
- Reset release, then alu_valid with rd=5, data=0xDEAD → alu_ready=1 that cycle; next cycle wb_en=1, wb_addr=5, wb_data=0xDEAD; afterwards wb_en=0.
- issue_en with rd=7, then mem writeback to rd=7 → busy[7] rises after the issue edge and stays high through wb_en. It clears one edge after wb_en in the base build, and on the wb_en-rise edge with WB_BYPASS_EN.
- Both valid continuously with STARVE_LIMIT=4 → grants are MEM×4, then ALU, then MEM×4, repeating; no cycle has both readies high.
- alu_valid with rd=0 and data=0x1234 → alu_ready=1; wb_en stays 0; busy unchanged.
- busy[9]=1 and pending clear of x9 while issue_en with rd=9 arrives the same edge → busy[9] remains 1.
- Drive reset low asynchronously mid-cycle during an active wb_en → wb_en, busy and readies go to 0 immediately, without waiting for a clock edge.
